// File: rtl/regfile_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter_if
// Purpose : Bundles the two writeback request channels (ALU "a_*" and
//           memory-load "m_*") and the register-file write port of the
//           regfile write arbiter.
// Signals :
//   a_valid/a_ready/a_regid/a_data : ALU writeback request channel
//   m_valid/m_ready/m_regid/m_data : memory-load writeback request channel
//   wr_en/wr_regid/wr_data         : registered register-file write port
//   pending                        : one bit per register with a write in flight
// Modports: master = request producers / write consumer (bench side),
//           slave  = the arbiter.
// ----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
   parameter int DATA_W = 16
);
   logic              a_valid;
   logic              a_ready;
   logic [3:0]        a_regid;
   logic [DATA_W-1:0] a_data;
   logic              m_valid;
   logic              m_ready;
   logic [3:0]        m_regid;
   logic [DATA_W-1:0] m_data;
   logic              wr_en;
   logic [3:0]        wr_regid;
   logic [DATA_W-1:0] wr_data;
   logic [15:0]       pending;

   modport master (
      output a_valid, a_regid, a_data,
      output m_valid, m_regid, m_data,
      input  a_ready, m_ready,
      input  wr_en, wr_regid, wr_data, pending
   );

   modport slave (
      input  a_valid, a_regid, a_data,
      input  m_valid, m_regid, m_data,
      output a_ready, m_ready,
      output wr_en, wr_regid, wr_data, pending
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter
// Purpose : Merges ALU and memory-load writebacks onto a single register-file
//           write port. Each requester owns a one-entry holding slot; among
//           full slots the older one is written first, equal-age ties are
//           broken by a round-robin pointer. The write port is registered.
// Ports   :
//   clk    : single clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : regfile_write_arbiter_if.slave (request channels, write port,
//            pending bitmap). Its DATA_W must match this module's DATA_W.
// Parameters:
//   DATA_W  : write data width
//   DROP_R0 : when 1, requests to register 0 are accepted and discarded
// ----------------------------------------------------------------------------
module regfile_write_arbiter #(
   parameter int DATA_W  = 16,
   parameter bit DROP_R0 = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   regfile_write_arbiter_if.slave  bus
);

   // Slot state
   logic              r_a_full, r_m_full;
   logic              r_a_age,  r_m_age;   // with both full, the set bit marks the older slot
   logic [3:0]        r_a_regid, r_m_regid;
   logic [DATA_W-1:0] r_a_data,  r_m_data;
   logic              r_rr;                // equal-age tie winner: 0 = A, 1 = M

   // Registered write port
   logic              r_wr_en;
   logic [3:0]        r_wr_regid;
   logic [DATA_W-1:0] r_wr_data;

   logic              w_tie;
   logic              w_gnt_a, w_gnt_m;
   logic              w_a_ready, w_m_ready;
   logic              w_a_drop, w_m_drop;
   logic              w_a_load, w_m_load;
   logic              w_a_full_nx, w_m_full_nx;
   logic              w_a_age_nx, w_m_age_nx;
   logic [15:0]       w_pending;

   // Arbitration: single full slot wins; two full slots go to the older one,
   // and only when they were loaded on the same edge does rr decide.
   always_comb begin
      w_tie   = r_a_full & r_m_full & (r_a_age == r_m_age);
      w_gnt_a = r_a_full & (~r_m_full | (w_tie ? ~r_rr : r_a_age));
      w_gnt_m = r_m_full & ~w_gnt_a;
   end

   // Ready depends only on state so a slot being drained can refill on the
   // same edge without a combinational path from valid.
   assign w_a_ready = ~r_a_full | w_gnt_a;
   assign w_m_ready = ~r_m_full | w_gnt_m;

   assign w_a_drop  = DROP_R0 && (bus.a_regid == 4'd0);
   assign w_m_drop  = DROP_R0 && (bus.m_regid == 4'd0);

   // A dropped request completes its handshake but never touches the slot.
   assign w_a_load  = bus.a_valid & w_a_ready & ~w_a_drop;
   assign w_m_load  = bus.m_valid & w_m_ready & ~w_m_drop;

   assign w_a_full_nx = w_a_load | (r_a_full & ~w_gnt_a);
   assign w_m_full_nx = w_m_load | (r_m_full & ~w_gnt_m);

   // Age update: a slot loaded next to a slot that keeps its old entry is the
   // younger one; two slots loaded on the same edge are equal (tie).
   always_comb begin
      w_a_age_nx = 1'b0;
      w_m_age_nx = 1'b0;
      if (w_a_full_nx && w_m_full_nx) begin
         if (w_a_load && !w_m_load) begin
            w_m_age_nx = 1'b1;
         end else if (w_m_load && !w_a_load) begin
            w_a_age_nx = 1'b1;
         end else if (!w_a_load && !w_m_load) begin
            w_a_age_nx = r_a_age;
            w_m_age_nx = r_m_age;
         end
      end
   end

   // Pending bitmap: held slots plus the write currently on the port.
   always_comb begin
      w_pending = 16'd0;
      if (r_a_full) w_pending[r_a_regid]  = 1'b1;
      if (r_m_full) w_pending[r_m_regid]  = 1'b1;
      if (r_wr_en)  w_pending[r_wr_regid] = 1'b1;
   end

   // Control and write-port registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_full   <= 1'b0;
         r_m_full   <= 1'b0;
         r_a_age    <= 1'b0;
         r_m_age    <= 1'b0;
         r_rr       <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_regid <= 4'd0;
         r_wr_data  <= '0;
      end else begin
         r_a_full <= w_a_full_nx;
         r_m_full <= w_m_full_nx;
         r_a_age  <= w_a_age_nx;
         r_m_age  <= w_m_age_nx;
         if (w_tie) begin
            r_rr <= ~r_rr;
         end
         r_wr_en <= w_gnt_a | w_gnt_m;
         if (w_gnt_a) begin
            r_wr_regid <= r_a_regid;
            r_wr_data  <= r_a_data;
         end else if (w_gnt_m) begin
            r_wr_regid <= r_m_regid;
            r_wr_data  <= r_m_data;
         end
      end
   end

   // Slot payload; qualified by the full bits, so no reset needed.
   always_ff @(posedge clk) begin
      if (w_a_load) begin
         r_a_regid <= bus.a_regid;
         r_a_data  <= bus.a_data;
      end
      if (w_m_load) begin
         r_m_regid <= bus.m_regid;
         r_m_data  <= bus.m_data;
      end
   end

   assign bus.a_ready  = w_a_ready;
   assign bus.m_ready  = w_m_ready;
   assign bus.wr_en    = r_wr_en;
   assign bus.wr_regid = r_wr_regid;
   assign bus.wr_data  = r_wr_data;
   assign bus.pending  = w_pending;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Purpose : Self-checking bench for regfile_write_arbiter. A table of
//           per-cycle {inputs, expected outputs} records covers single
//           writes, ties, ordering, ageing and register-0 drops; hand-written
//           sequences cover back-to-back streaming and reset mid-stream.
// ----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

   logic clk;
   logic rst_n;

   int n_chk;
   int n_fail;

   regfile_write_arbiter_if #(.DATA_W(16)) bus ();

   regfile_write_arbiter #(
      .DATA_W  (16),
      .DROP_R0 (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        av;
      logic [3:0]  ar;
      logic [15:0] ad;
      logic        mv;
      logic [3:0]  mr;
      logic [15:0] md;
      logic        e_ardy;
      logic        e_mrdy;
      logic        e_wen;
      logic [3:0]  e_wreg;
      logic [15:0] e_wdat;
      logic [15:0] e_pend;
   } vec_t;

   localparam int NV = 35;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                               input logic mv, input logic [3:0] mr, input logic [15:0] md,
                               input logic ardy, input logic mrdy, input logic wen,
                               input logic [3:0] wreg, input logic [15:0] wdat,
                               input logic [15:0] pend);
      vec_t v;
      v.av = av; v.ar = ar; v.ad = ad;
      v.mv = mv; v.mr = mr; v.md = md;
      v.e_ardy = ardy; v.e_mrdy = mrdy; v.e_wen = wen;
      v.e_wreg = wreg; v.e_wdat = wdat; v.e_pend = pend;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.a_valid = 1'b0; bus.a_regid = 4'd0; bus.a_data = 16'd0;
      bus.m_valid = 1'b0; bus.m_regid = 4'd0; bus.m_data = 16'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Safety net in case the run ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int ia, im, k, first_c, last_c;
      logic ha, hm;
      logic [3:0]  er;
      logic [15:0] ed;

      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      idle_inputs();

      // Reset state
      #2;
      chk("rst_wr_en",    {31'd0, bus.wr_en},    32'd0);
      chk("rst_wr_regid", {28'd0, bus.wr_regid}, 32'd0);
      chk("rst_wr_data",  {16'd0, bus.wr_data},  32'd0);
      chk("rst_pending",  {16'd0, bus.pending},  32'd0);
      chk("rst_a_ready",  {31'd0, bus.a_ready},  32'd1);
      chk("rst_m_ready",  {31'd0, bus.m_ready},  32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      //            av ar     ad      mv mr     md     ardy mrdy wen wreg   wdat     pend
      vecs[0]  = mk(1, 4'd3,  16'h1234, 0, 4'd0,  16'h0000, 1, 1, 0, 4'd0,  16'h0000, 16'h0000);
      vecs[1]  = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 0, 4'd0,  16'h0000, 16'h0008);
      vecs[2]  = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 1, 4'd3,  16'h1234, 16'h0008);
      vecs[3]  = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 0, 4'd3,  16'h1234, 16'h0000);
      vecs[4]  = mk(1, 4'd5,  16'hAAAA, 1, 4'd6,  16'hBBBB, 1, 1, 0, 4'd3,  16'h1234, 16'h0000);
      vecs[5]  = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 0, 0, 4'd3,  16'h1234, 16'h0060);
      vecs[6]  = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 1, 4'd5,  16'hAAAA, 16'h0060);
      vecs[7]  = mk(1, 4'd8,  16'hCCCC, 1, 4'd9,  16'hDDDD, 1, 1, 1, 4'd6,  16'hBBBB, 16'h0040);
      vecs[8]  = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 1, 0, 4'd6,  16'hBBBB, 16'h0300);
      vecs[9]  = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 1, 4'd9,  16'hDDDD, 16'h0300);
      vecs[10] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 1, 4'd8,  16'hCCCC, 16'h0100);
      vecs[11] = mk(0, 4'd0,  16'h0000, 1, 4'd7,  16'h0001, 1, 1, 0, 4'd8,  16'hCCCC, 16'h0000);
      vecs[12] = mk(1, 4'd7,  16'h0002, 0, 4'd0,  16'h0000, 1, 1, 0, 4'd8,  16'hCCCC, 16'h0080);
      vecs[13] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 1, 4'd7,  16'h0001, 16'h0080);
      vecs[14] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 1, 4'd7,  16'h0002, 16'h0080);
      vecs[15] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 0, 4'd7,  16'h0002, 16'h0000);
      vecs[16] = mk(0, 4'd0,  16'h0000, 1, 4'd1,  16'h0101, 1, 1, 0, 4'd7,  16'h0002, 16'h0000);
      vecs[17] = mk(1, 4'd2,  16'h0202, 1, 4'd3,  16'h0303, 1, 1, 0, 4'd7,  16'h0002, 16'h0002);
      vecs[18] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 0, 1, 4'd1,  16'h0101, 16'h000E);
      vecs[19] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 1, 4'd2,  16'h0202, 16'h000C);
      vecs[20] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 1, 4'd3,  16'h0303, 16'h0008);
      vecs[21] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 0, 4'd3,  16'h0303, 16'h0000);
      vecs[22] = mk(1, 4'd0,  16'h5555, 0, 4'd0,  16'h0000, 1, 1, 0, 4'd3,  16'h0303, 16'h0000);
      vecs[23] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 0, 4'd3,  16'h0303, 16'h0000);
      vecs[24] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 0, 4'd3,  16'h0303, 16'h0000);
      vecs[25] = mk(0, 4'd0,  16'h0000, 1, 4'd4,  16'h0404, 1, 1, 0, 4'd3,  16'h0303, 16'h0000);
      vecs[26] = mk(1, 4'd0,  16'h5555, 1, 4'd10, 16'h0A0A, 1, 1, 0, 4'd3,  16'h0303, 16'h0010);
      vecs[27] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 1, 4'd4,  16'h0404, 16'h0410);
      vecs[28] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 1, 4'd10, 16'h0A0A, 16'h0400);
      vecs[29] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 0, 4'd10, 16'h0A0A, 16'h0000);
      vecs[30] = mk(1, 4'd11, 16'h0B0B, 1, 4'd12, 16'h0C0C, 1, 1, 0, 4'd10, 16'h0A0A, 16'h0000);
      vecs[31] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 1, 0, 4'd10, 16'h0A0A, 16'h1800);
      vecs[32] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 1, 4'd12, 16'h0C0C, 16'h1800);
      vecs[33] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 1, 4'd11, 16'h0B0B, 16'h0800);
      vecs[34] = mk(0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 1, 0, 4'd11, 16'h0B0B, 16'h0000);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         bus.a_valid = vecs[i].av; bus.a_regid = vecs[i].ar; bus.a_data = vecs[i].ad;
         bus.m_valid = vecs[i].mv; bus.m_regid = vecs[i].mr; bus.m_data = vecs[i].md;
         #1;
         chk($sformatf("v%0d_a_ready", i),  {31'd0, bus.a_ready},  {31'd0, vecs[i].e_ardy});
         chk($sformatf("v%0d_m_ready", i),  {31'd0, bus.m_ready},  {31'd0, vecs[i].e_mrdy});
         chk($sformatf("v%0d_wr_en", i),    {31'd0, bus.wr_en},    {31'd0, vecs[i].e_wen});
         chk($sformatf("v%0d_wr_regid", i), {28'd0, bus.wr_regid}, {28'd0, vecs[i].e_wreg});
         chk($sformatf("v%0d_wr_data", i),  {16'd0, bus.wr_data},  {16'd0, vecs[i].e_wdat});
         chk($sformatf("v%0d_pending", i),  {16'd0, bus.pending},  {16'd0, vecs[i].e_pend});
      end

      // Back-to-back streaming: 8 requests per requester, each held until
      // accepted. Expected order alternates A0 M0 A1 M1 ... from the
      // initial tie (rr = 0 after reset).
      do_reset();
      ia = 0; im = 0; k = 0; first_c = -1; last_c = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         bus.a_valid = (ia < 8);
         bus.a_regid = 4'(ia + 1);
         bus.a_data  = 16'hA000 + 16'(ia);
         bus.m_valid = (im < 8);
         bus.m_regid = 4'(15 - im);
         bus.m_data  = 16'hB000 + 16'(im);
         #1;
         ha = bus.a_valid & bus.a_ready;
         hm = bus.m_valid & bus.m_ready;
         if (bus.wr_en) begin
            if (first_c < 0) first_c = c;
            last_c = c;
            if (k < 16) begin
               er = (k % 2 == 0) ? 4'(k / 2 + 1) : 4'(15 - k / 2);
               ed = (k % 2 == 0) ? 16'hA000 + 16'(k / 2) : 16'hB000 + 16'(k / 2);
               chk($sformatf("b2b_w%0d_regid", k), {28'd0, bus.wr_regid}, {28'd0, er});
               chk($sformatf("b2b_w%0d_data", k),  {16'd0, bus.wr_data},  {16'd0, ed});
            end else begin
               chk("b2b_extra_write", 32'(k), 32'd15);
            end
            k++;
         end
         if (ha) ia++;
         if (hm) im++;
      end
      chk("b2b_a_accepted", 32'(ia), 32'd8);
      chk("b2b_m_accepted", 32'(im), 32'd8);
      chk("b2b_write_count", 32'(k), 32'd16);
      chk("b2b_contiguous", 32'(last_c - first_c), 32'd15);
      chk("b2b_pending_end", {16'd0, bus.pending}, 32'd0);

      // Reset mid-stream with both slots full and a write on the port.
      do_reset();
      @(negedge clk);
      bus.a_valid = 1'b1; bus.a_regid = 4'd13; bus.a_data = 16'h1313;
      bus.m_valid = 1'b1; bus.m_regid = 4'd14; bus.m_data = 16'h1414;
      @(negedge clk);
      bus.a_valid = 1'b1; bus.a_regid = 4'd11; bus.a_data = 16'h1111;
      bus.m_valid = 1'b0;
      @(negedge clk);
      idle_inputs();
      #1;
      chk("mid_pre_wr_en",   {31'd0, bus.wr_en},    32'd1);
      chk("mid_pre_regid",   {28'd0, bus.wr_regid}, 32'd13);
      chk("mid_pre_pending", {16'd0, bus.pending},  32'h6800);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr_en",   {31'd0, bus.wr_en},    32'd0);
      chk("mid_rst_pending", {16'd0, bus.pending},  32'd0);
      chk("mid_rst_a_ready", {31'd0, bus.a_ready},  32'd1);
      chk("mid_rst_m_ready", {31'd0, bus.m_ready},  32'd1);
      chk("mid_rst_wr_data", {16'd0, bus.wr_data},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post_rst%0d_wr_en", c),   {31'd0, bus.wr_en},   32'd0);
         chk($sformatf("post_rst%0d_pending", c), {16'd0, bus.pending}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, width of write data.
REQ-002 Parameter: DROP_R0, 1, when 1 writes to register 0 are accepted and discarded.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a_valid  input  1  ALU writeback request.
REQ-006 a_ready  output  1  ALU slot can accept this cycle.
REQ-007 a_regid  input  4  ALU destination register.
REQ-008 a_data  input  DATA_W  ALU write data.
REQ-009 m_valid  input  1  memory-load writeback request.
REQ-010 m_ready  output  1  memory slot can accept this cycle.
REQ-011 m_regid  input  4  memory destination register.
REQ-012 m_data  input  DATA_W  memory write data.
REQ-013 wr_en  output  1  register-file write enable (feeds write decoder).
REQ-014 wr_regid  output  4  register-file write address.
REQ-015 wr_data  output  DATA_W  register-file write data.
REQ-016 pending  output  16  bit r high while a write to register r is held in a slot or in the wr_* output register.

Function
REQ-017 Two one-entry holding slots (A, M), each: full bit, regid, data, age bit; handshake completes on a rising edge with x_valid and x_ready high.
REQ-018 x_ready = slot empty, or slot full and granted this cycle; purely combinational from state, never from x_valid.
REQ-019 Accepted request with regid 0 and DROP_R0=1: handshake completes, slot stays unchanged, no write, no pending bit.
REQ-020 Arbitration each cycle among full slots: single full slot is granted; both full -> older slot granted.
REQ-021 Both slots loaded on the same edge (equal age): tie broken by round-robin pointer rr (0=A, 1=M); rr toggles only on a tie-broken grant.
REQ-022 Slot loaded while the other slot is already full is marked younger; write order per requester and across requesters equals acceptance order.
REQ-023 Grant at cycle N: on edge ending cycle N, wr_en<=1, wr_regid/wr_data<=granted slot contents, slot cleared unless refilled by a same-edge handshake.
REQ-024 No grant in cycle N: wr_en<=0 at that edge; wr_regid/wr_data hold last values.
REQ-025 Latency: request accepted at edge E with other slot empty -> wr_en high in cycle after edge E+1; register file writes at edge E+2.
REQ-026 Throughput: one write per cycle sustained; each slot accepts one request per cycle when continuously granted.
REQ-027 Same-regid entries in both slots: both written, older first; final register value = younger data.
REQ-028 pending = OR of decoded regid of full slots and of wr_regid when wr_en=1; combinational.
REQ-029 rr, age and slot state never updated by a dropped (regid 0) request.

Reset
REQ-030 rst_n low asynchronously clears: both slot full bits, wr_en=0, wr_regid=0, wr_data=0, rr=0, ages; pending=0, a_ready=1, m_ready=1 while in reset.
REQ-031 Reset asserted mid-operation discards all held writes; no wr_en pulse after release until a new handshake.
REQ-032 Release of rst_n synchronized by the integrating design; first handshake allowed on first rising edge with rst_n high.

Verification
REQ-033 Single ALU write: a_valid, a_regid=3, a_data=0x1234 one cycle -> wr_en=1, wr_regid=3, wr_data=0x1234 exactly one cycle, two edges later; pending[3] high from edge E to write completion.
REQ-034 Tie: A(5,0xAAAA), M(6,0xBBBB) same edge after reset -> A written first, M next cycle; repeat tie -> M first.
REQ-035 Ordering: M(7,0x0001) accepted, next edge A(7,0x0002) -> writes to r7 in order 0x0001 then 0x0002; pending[7] clear after second.
REQ-036 Back-to-back: a_valid and m_valid held high 8 cycles, distinct regids -> 16 writes over 16 cycles, ready deasserts per slot only while older slot waits, no loss or duplication.
REQ-037 Drop: a_regid=0, DROP_R0=1 -> a_ready=1, handshake completes, no wr_en, pending=0.
REQ-038 Reset mid-stream: rst_n low while both slots full -> wr_en=0, pending=0 immediately; no writes after release.
